// File: rtl/ex3_bcd_decoder_if.sv
// Valid/ready stream bundle for ex3_bcd_decoder: Excess-3 digit input side and packed-BCD word output side.
// out_errpos exists only when EX3_ERRPOS_EN is defined.
interface ex3_bcd_decoder_if #(
    parameter int DIGITS = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_digit;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [3:0]            out_count;
    logic                  out_error;
    logic                  out_full;
`ifdef EX3_ERRPOS_EN
    logic [3:0]            out_errpos;
`endif

    modport slave (
        input  in_valid, in_digit, in_last, out_ready,
        output in_ready, out_valid, out_bcd, out_count, out_error, out_full
`ifdef EX3_ERRPOS_EN
        , output out_errpos
`endif
    );

    modport master (
        output in_valid, in_digit, in_last, out_ready,
        input  in_ready, out_valid, out_bcd, out_count, out_error, out_full
`ifdef EX3_ERRPOS_EN
        , input out_errpos
`endif
    );
endinterface

// File: rtl/ex3_bcd_decoder.sv
// Digit-serial Excess-3 to packed-BCD decoder: collects up to DIGITS digits, then holds the word until taken.
// Optional first-error arrival index on out_errpos when EX3_ERRPOS_EN is defined.
module ex3_bcd_decoder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    ex3_bcd_decoder_if.slave    bus
);
    localparam int         BCD_W    = 4 * DIGITS;
    localparam logic [3:0] DIGITS_W = 4'(DIGITS);

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_HOLD   = 1'b1
    } state_e;

    function automatic logic ex3_code_ok(input logic [3:0] code);
        return (code >= 4'h3) && (code <= 4'hC);
    endfunction

    // Invalid codes collapse to zero; the error flag records them separately.
    function automatic logic [3:0] ex3_decode(input logic [3:0] code);
        return ex3_code_ok(code) ? (code - 4'h3) : 4'h0;
    endfunction

    state_e              state_q;
    logic [BCD_W-1:0]    acc_q;
    logic [BCD_W-1:0]    acc_d;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic                err_q;
    logic                err_d;
    logic [BCD_W-1:0]    bcd_q;
    logic [3:0]          count_q;
    logic                error_q;
    logic                full_q;
    logic                digit_bad_s;
    logic                at_limit_s;
    logic                close_s;
    logic                in_hs_s;
    logic                out_hs_s;
`ifdef EX3_ERRPOS_EN
    logic [3:0]          errpos_q;
    logic [3:0]          errpos_d;
    logic [3:0]          errpos_out_q;
`endif

    // Accumulator and word-close values as they would be with the presented digit included.
    always_comb begin
        digit_bad_s = !ex3_code_ok(bus.in_digit);
        acc_d       = (acc_q << 4'd4) | BCD_W'(ex3_decode(bus.in_digit));
        cnt_d       = cnt_q + 4'd1;
        err_d       = err_q | digit_bad_s;
        at_limit_s  = (cnt_d == DIGITS_W);
        close_s     = bus.in_last || at_limit_s;
        in_hs_s     = bus.in_valid && (state_q == ST_ACCEPT);
        out_hs_s    = bus.out_ready && (state_q == ST_HOLD);
`ifdef EX3_ERRPOS_EN
        if (err_q) begin
            errpos_d = errpos_q;
        end else if (digit_bad_s) begin
            errpos_d = cnt_q;
        end else begin
            errpos_d = 4'd0;
        end
`endif
    end

    // Accept/hold FSM with the accumulator and the registered output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ACCEPT;
            acc_q        <= '0;
            cnt_q        <= 4'd0;
            err_q        <= 1'b0;
            bcd_q        <= '0;
            count_q      <= 4'd0;
            error_q      <= 1'b0;
            full_q       <= 1'b0;
`ifdef EX3_ERRPOS_EN
            errpos_q     <= 4'd0;
            errpos_out_q <= 4'd0;
`endif
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (in_hs_s) begin
                        if (close_s) begin
                            bcd_q        <= acc_d;
                            count_q      <= cnt_d;
                            error_q      <= err_d;
                            full_q       <= at_limit_s && !bus.in_last;
`ifdef EX3_ERRPOS_EN
                            errpos_out_q <= errpos_d;
`endif
                            state_q      <= ST_HOLD;
                        end else begin
                            acc_q    <= acc_d;
                            cnt_q    <= cnt_d;
                            err_q    <= err_d;
`ifdef EX3_ERRPOS_EN
                            errpos_q <= errpos_d;
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_hs_s) begin
                        acc_q    <= '0;
                        cnt_q    <= 4'd0;
                        err_q    <= 1'b0;
`ifdef EX3_ERRPOS_EN
                        errpos_q <= 4'd0;
`endif
                        state_q  <= ST_ACCEPT;
                    end
                end
                default: begin
                    state_q <= ST_ACCEPT;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == ST_ACCEPT);
    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.out_bcd    = bcd_q;
    assign bus.out_count  = count_q;
    assign bus.out_error  = error_q;
    assign bus.out_full   = full_q;
`ifdef EX3_ERRPOS_EN
    assign bus.out_errpos = errpos_out_q;
`endif

endmodule

// File: tb/tb_ex3_bcd_decoder.sv
// Directed bench for ex3_bcd_decoder (DIGITS=4): table of single words plus multi-cycle corner sequences.
module tb_ex3_bcd_decoder;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    ex3_bcd_decoder_if #(.DIGITS(4)) bus ();

    ex3_bcd_decoder #(.DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] digs;
        logic [3:0]  lastm;
        logic [15:0] bcd;
        logic [3:0]  cnt;
        logic        err;
        logic        full;
        logic [3:0]  epos;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_digit = d;
        bus.in_last  = l;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_digit = 4'hF;
        bus.in_last  = 1'b0;
    endtask

    task automatic take(input string nm, input logic [15:0] eb, input logic [3:0] ec,
                        input logic ee, input logic ef, input logic [3:0] ep);
        int t;
        t = 0;
        chk({nm, "_latency"}, 32'(bus.out_valid), 32'd1);
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_bcd"},   32'(bus.out_bcd),   32'(eb));
        chk({nm, "_count"}, 32'(bus.out_count), 32'(ec));
        chk({nm, "_error"}, 32'(bus.out_error), 32'(ee));
        chk({nm, "_full"},  32'(bus.out_full),  32'(ef));
`ifdef EX3_ERRPOS_EN
        chk({nm, "_errpos"}, 32'(bus.out_errpos), 32'(ep));
`else
        if (ep > 4'd15) chk({nm, "_errpos_range"}, 32'(ep), 32'd0);
`endif
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({nm, "_valid_after"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_ready_after"}, 32'(bus.in_ready),  32'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_bcd"},   32'(bus.out_bcd),   32'd0);
        chk({nm, "_count"}, 32'(bus.out_count), 32'd0);
        chk({nm, "_error"}, 32'(bus.out_error), 32'd0);
        chk({nm, "_full"},  32'(bus.out_full),  32'd0);
`ifdef EX3_ERRPOS_EN
        chk({nm, "_errpos"}, 32'(bus.out_errpos), 32'd0);
`endif
    endtask

    initial begin
        logic [3:0] hold_digs [5];
        n_cmp  = 0;
        n_fail = 0;

        tbl[0] = '{n:3, digs:16'h48C0, lastm:4'b0100, bcd:16'h0159, cnt:4'd3, err:1'b0, full:1'b0, epos:4'd0};
        tbl[1] = '{n:3, digs:16'h6E30, lastm:4'b0100, bcd:16'h0300, cnt:4'd3, err:1'b1, full:1'b0, epos:4'd1};
        tbl[2] = '{n:4, digs:16'h3456, lastm:4'b1000, bcd:16'h0123, cnt:4'd4, err:1'b0, full:1'b0, epos:4'd0};
        tbl[3] = '{n:1, digs:16'h3000, lastm:4'b0001, bcd:16'h0000, cnt:4'd1, err:1'b0, full:1'b0, epos:4'd0};
        tbl[4] = '{n:1, digs:16'hC000, lastm:4'b0001, bcd:16'h0009, cnt:4'd1, err:1'b0, full:1'b0, epos:4'd0};
        tbl[5] = '{n:1, digs:16'h2000, lastm:4'b0001, bcd:16'h0000, cnt:4'd1, err:1'b1, full:1'b0, epos:4'd0};
        tbl[6] = '{n:1, digs:16'hD000, lastm:4'b0001, bcd:16'h0000, cnt:4'd1, err:1'b1, full:1'b0, epos:4'd0};
        tbl[7] = '{n:4, digs:16'h0F71, lastm:4'b1000, bcd:16'h0040, cnt:4'd4, err:1'b1, full:1'b0, epos:4'd0};
        tbl[8] = '{n:4, digs:16'h5C4E, lastm:4'b0000, bcd:16'h2910, cnt:4'd4, err:1'b1, full:1'b1, epos:4'd3};
        tbl[9] = '{n:2, digs:16'h9A00, lastm:4'b0010, bcd:16'h0067, cnt:4'd2, err:1'b0, full:1'b0, epos:4'd0};

        hold_digs[0] = 4'h3;
        hold_digs[1] = 4'h7;
        hold_digs[2] = 4'hC;
        hold_digs[3] = 4'h0;
        hold_digs[4] = 4'h9;

        // Reset with a would-be closing handshake presented; it must be ignored.
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_digit  = 4'hC;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_ready", 32'(bus.in_ready),  32'd1);
        chk("post_reset_valid", 32'(bus.out_valid), 32'd0);

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < tbl[v].n; i++) begin
                send(tbl[v].digs[15-4*i -: 4], tbl[v].lastm[i]);
            end
            take($sformatf("vec%0d", v), tbl[v].bcd, tbl[v].cnt, tbl[v].err, tbl[v].full, tbl[v].epos);
        end

        // Full word closes without in_last; the fifth digit opens a new word.
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        take("full_w1", 16'h0123, 4'd4, 1'b0, 1'b1, 4'd0);
        send(4'h7, 1'b1);
        take("full_w2", 16'h0004, 4'd1, 1'b0, 1'b0, 4'd0);

        // Held word must stay frozen while input traffic is presented.
        send(4'h4, 1'b0);
        send(4'h5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_digit = hold_digs[k];
            bus.in_last  = k[0];
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_bcd",   32'(bus.out_bcd),   32'h0012);
            chk("hold_ready", 32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("hold_release_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_release_ready", 32'(bus.in_ready),  32'd1);
        send(4'hB, 1'b1);
        take("after_hold", 16'h0008, 4'd1, 1'b0, 1'b0, 4'd0);

        // Reset mid-word discards the partial digits.
        send(4'h5, 1'b0);
        send(4'h9, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        send(4'hA, 1'b1);
        take("rst_mid_word", 16'h0007, 4'd1, 1'b0, 1'b0, 4'd0);

        // Reset during HOLD discards a word carrying error and full flags.
        send(4'h4, 1'b0);
        send(4'hE, 1'b0);
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        chk("rst_hold_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("rst_hold_pre_bcd",   32'(bus.out_bcd),   32'h1023);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_ready", 32'(bus.in_ready),  32'd1);
        chk("rst_hold_valid", 32'(bus.out_valid), 32'd0);
        send(4'hC, 1'b1);
        take("rst_hold_word", 16'h0009, 4'd1, 1'b0, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ex3_bcd_decoder.md
# ex3_bcd_decoder

Digit-serial Excess-3 to packed-BCD decoder. It accepts one Excess-3 digit per valid/ready handshake, subtracts 3, and accumulates the digits into a right-aligned packed-BCD word. It then presents the word together with a digit count and error/overflow flags on an output valid/ready handshake. It is the receive-side counterpart of the BCD-to-Excess-3 converter: the converter's Excess-3 output is serialised into this block, which rebuilds the multi-digit BCD number.

## Interface
- `DIGITS`, default 4: maximum digits per output word; legal range 1..15.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_digit`/`in_last` are valid.
- `in_ready`  out  1  block can accept a digit.
- `in_digit`  in  4  Excess-3 code, bit 3 = MSB.
- `in_last`  in  1  this digit is the least significant digit of the number.
- `out_valid`  out  1  output word is valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_bcd`  out  4*DIGITS  packed BCD, right-aligned; unused high nibbles are 0.
- `out_count`  out  4  number of digits in the word (1..DIGITS).
- `out_error`  out  1  at least one digit in the word was an invalid Excess-3 code.
- `out_full`  out  1  word was closed by reaching DIGITS digits without `in_last`.
- `out_errpos`  out  4  present only with `EX3_ERRPOS_EN`; see Configuration.

## Operation
- Two states: ACCEPT and HOLD. Reset enters ACCEPT.
- ACCEPT
  - `in_ready`=1 and `out_valid`=0.
  - A digit is accepted when `in_valid`&&`in_ready`.
  - Valid codes are 0x3..0xC; the decoded digit is `in_digit`-3, 4-bit.
  - Invalid codes (0x0, 0x1, 0x2, 0xD, 0xE, 0xF) decode to 0 and set the sticky `err` bit for the word.
  - Accumulation: `acc` <= {`acc`[4*DIGITS-5:0], digit}, so the first digit received ends up most significant. `cnt` increments on each accepted digit.
  - The word closes on the accepted digit when `in_last`=1 or when `cnt`+1==DIGITS.
  - `full` = (`cnt`+1==DIGITS) && !`in_last`.
  - On close, the output registers load `acc`/`cnt`/`err`/`full` including the closing digit, and the state moves to HOLD.
- HOLD
  - `out_valid`=1 and `in_ready`=0. All outputs are stable until `out_valid`&&`out_ready`.
  - On that output handshake: the accumulator, `cnt` and `err` clear, and the state returns to ACCEPT.
- There is no input/output overlap. `in_ready` is 0 in the cycle of the output handshake.
- `in_digit` and `in_last` are don't-care when `in_valid`=0 or `in_ready`=0.

## Timing
- Reset values: `out_valid`=0, `out_bcd`=0, `out_count`=0, `out_error`=0, `out_full`=0, `out_errpos`=0, internal `acc`/`cnt`/`err`=0.
- `in_ready`=1 from the first cycle after `reset` deasserts. While `reset`=1, handshakes are ignored.
- Latency: `out_valid` rises in the cycle after the closing digit's handshake.
- `in_ready` rises in the cycle after the output handshake.
- Minimum cycles per N-digit word: N + 1, when `out_ready` is held at 1.
- Reset asserted mid-word or during HOLD discards the partial or held word. No output is produced for it.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready`.

## Configuration
- `EX3_ERRPOS_EN` defined:
  - Port `out_errpos` [3:0] exists.
  - It holds the 0-based arrival index of the first invalid digit in the word, where 0 is the first digit received.
  - It is 0 when `out_error`=0.
  - The capture register is held once `err` is set.
- `EX3_ERRPOS_EN` undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- DIGITS=4; digits 0x4, 0x8, 0xC with `in_last` on 0xC -> `out_bcd`=0x0159, `out_count`=3, `out_error`=0, `out_full`=0, `out_valid` one cycle after the third handshake.
- Digits 0x6, 0xE, 0x3 with `in_last` on 0x3 -> `out_bcd`=0x0300, `out_count`=3, `out_error`=1; with `EX3_ERRPOS_EN`, `out_errpos`=1.
- Digits 0x3, 0x4, 0x5, 0x6, 0x7 with no `in_last` -> first word `out_bcd`=0x0123, `out_count`=4, `out_full`=1. The fifth digit (0x7) is accepted after the output handshake and starts a new word holding 0x4. Same stream with `in_last` on 0x6 -> `out_full`=0.
- Word held with `out_ready`=0 for 5 cycles while `in_valid`=1 with changing `in_digit` -> `out_valid` and `out_bcd` stable, `in_ready`=0, no digits consumed. `out_ready`=1 -> one handshake, then `in_ready`=1 on the next cycle.
- Accept 0x5, 0x9, then `reset` for 1 cycle, then 0xA with `in_last` -> single word `out_bcd`=0x0007, `out_count`=1; all outputs equal their reset values during reset.
- Boundary codes as single-digit words: 0x3 -> 0x0000 with `error`=0; 0xC -> 0x0009; 0x2 -> 0x0000 with `error`=1; 0xD -> 0x0000 with `error`=1.
